data_sampling_mv: RTL and testbench

Parametrised majority-vote sampler for the UART receiver. It replaces the fixed three-sample data sampler and takes the same edge counter and prescale inputs from the RX edge/bit counter. It captures NUM_SAMPLES oversampled points centred on the bit midpoint and produces a registered bit decision with a one-cycle valid strobe. It also flags noise, supports a single-sample bypass mode and detects prescale settings too small for the sampling window.

---
 rtl/data_sampling_mv.sv | 156 +++++++++++++++
 tb/tb_data_sampling_mv.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sampling_mv.sv
// Majority-vote bit sampler for the UART receiver.
// Captures NUM_SAMPLES oversampled points centred on the bit midpoint. The
// decision is registered on the edge that sees the last point of the window,
// together with a one-cycle valid strobe and a noise flag. If the prescale
// is too small for the window, the block falls back to one centre sample.
module data_sampling_mv #(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  data_samp_en,
  input  logic                  maj_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sampled_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);

  // One extra bit of headroom so that mid/first/last never wrap for legal
  // settings.
  localparam int W1 = PRESCALE_W + 1;
  localparam int H  = (NUM_SAMPLES - 1) / 2;
  // The last window point is taken live from RX_IN, so only N-1 points are
  // stored. The register keeps a width of at least one bit.
  localparam int SW = (NUM_SAMPLES > 1) ? NUM_SAMPLES - 1 : 1;
  localparam int CW = $clog2(NUM_SAMPLES + 1);

  localparam logic [W1-1:0] HALF_WIN = W1'(H);
  localparam logic [W1-1:0] MIN_PRE  = W1'(NUM_SAMPLES + 1);
  localparam logic [W1-1:0] ONE_W    = W1'(1);
  localparam logic [W1-1:0] TWO_W    = W1'(2);
  localparam logic [CW-1:0] MAJ_TH   = CW'(H + 1);
  localparam logic [CW-1:0] ALL_CNT  = CW'(NUM_SAMPLES);

  // Count the ones in the sample window.
  function automatic logic [CW-1:0] popcount(input logic [NUM_SAMPLES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [W1-1:0]          presc_ext_s;
  logic [W1-1:0]          edge_ext_s;
  logic [W1-1:0]          mid_s;
  logic [W1-1:0]          first_s;
  logic [W1-1:0]          last_s;
  logic [NUM_SAMPLES-1:0] window_s;
  logic [CW-1:0]          cnt_s;
  logic                   dec_bit_s;
  logic                   dec_noise_s;
  logic                   at_last_s;
  logic                   at_mid_s;
  logic                   fb_ok_s;
  logic                   cfg_next_s;

  logic [SW-1:0] sample_r;
  logic          bit_r;
  logic          valid_r;
  logic          noise_r;
  logic          cfg_r;

  // Window geometry from the current prescale.
  always_comb begin
    presc_ext_s = {1'b0, Prescale};
    edge_ext_s  = {1'b0, edge_cnt};
    mid_s       = (presc_ext_s >> 1) - ONE_W;
    first_s     = mid_s - HALF_WIN;
    last_s      = mid_s + HALF_WIN;
    at_last_s   = (edge_ext_s == last_s);
    at_mid_s    = (edge_ext_s == mid_s);
    fb_ok_s     = (presc_ext_s >= TWO_W);
    cfg_next_s  = (presc_ext_s < MIN_PRE);
  end

  // Assemble the full window (stored points plus the live RX_IN) and form the decision.
  always_comb begin
    window_s = '0;
    for (int i = 0; i < NUM_SAMPLES - 1; i++) begin
      window_s[i] = sample_r[i];
    end
    window_s[NUM_SAMPLES-1] = RX_IN;
    cnt_s = popcount(window_s);
    if (maj_en) begin
      dec_bit_s   = (cnt_s >= MAJ_TH);
      dec_noise_s = (cnt_s != '0) && (cnt_s != ALL_CNT);
    end else begin
      dec_bit_s   = window_s[H];
      dec_noise_s = 1'b0;
    end
  end

  // The configuration error flag follows Prescale every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cfg_r <= 1'b0;
    end else begin
      cfg_r <= cfg_next_s;
    end
  end

  // Store the window points before the last one. Clear them whenever sampling is disabled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_r <= '0;
    end else if (!data_samp_en) begin
      sample_r <= '0;
    end else if (!cfg_r) begin
      for (int i = 0; i < NUM_SAMPLES - 1; i++) begin
        if (edge_ext_s == (first_s + W1'(i))) begin
          sample_r[i] <= RX_IN;
        end
      end
    end
  end

  // Register the decision, the valid strobe and the noise flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_r   <= 1'b0;
      valid_r <= 1'b0;
      noise_r <= 1'b0;
    end else if (!data_samp_en) begin
      bit_r   <= 1'b0;
      valid_r <= 1'b0;
      noise_r <= 1'b0;
    end else if (!cfg_r) begin
      if (at_last_s) begin
        bit_r   <= dec_bit_s;
        noise_r <= dec_noise_s;
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end else if (fb_ok_s && at_mid_s) begin
      // The window does not fit, so use one sample at the bit centre.
      bit_r   <= RX_IN;
      noise_r <= 1'b0;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign sampled_bit   = bit_r;
  assign sampled_valid = valid_r;
  assign noise_err     = noise_r;
  assign cfg_err       = cfg_r;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Bench for data_sampling_mv. It runs two instances, N=3 and N=5, on shared
// stimulus. A behavioural model keeps, for each instance, the RX value seen
// at each edge index of the current bit. The model decides from those
// values using the window arithmetic. A table of expected values covers the
// N=3 basic cases, and hand-written sequences cover the multi-cycle corners.
module tb_data_sampling_mv;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [5:0] presc;
  logic       en;
  logic       maj;
  logic [5:0] edge_c;
  logic       b3, v3, n3, c3;
  logic       b5, v5, n5, c5;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit   hist[2][64];
  logic m_bit[2], m_val[2], m_noise[2], m_cfg[2];

  always #5 clk = ~clk;

  data_sampling_mv #(.PRESCALE_W(6), .NUM_SAMPLES(3)) u3 (
    .CLK(clk), .RST(rst), .RX_IN(rx), .Prescale(presc), .data_samp_en(en),
    .maj_en(maj), .edge_cnt(edge_c), .sampled_bit(b3), .sampled_valid(v3),
    .noise_err(n3), .cfg_err(c3));

  data_sampling_mv #(.PRESCALE_W(6), .NUM_SAMPLES(5)) u5 (
    .CLK(clk), .RST(rst), .RX_IN(rx), .Prescale(presc), .data_samp_en(en),
    .maj_en(maj), .edge_cnt(edge_c), .sampled_bit(b5), .sampled_valid(v5),
    .noise_err(n5), .cfg_err(c5));

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) hist[k][i] = 1'b0;
      m_bit[k] = 1'b0; m_val[k] = 1'b0; m_noise[k] = 1'b0; m_cfg[k] = 1'b0;
    end
  endtask

  // Compute what one instance shows after the coming edge, from the driven inputs.
  task automatic model_eval(input int k, input int n);
    int h, p, e, mid, first, last, ones;
    logic new_cfg;
    h = (n - 1) / 2;
    p = int'(presc);
    e = int'(edge_c);
    mid = p / 2 - 1;
    first = mid - h;
    last = mid + h;
    new_cfg = (p < n + 1);
    if (!en) begin
      for (int i = 0; i < 64; i++) hist[k][i] = 1'b0;
      m_bit[k] = 1'b0; m_val[k] = 1'b0; m_noise[k] = 1'b0;
    end else if (!m_cfg[k]) begin
      m_val[k] = 1'b0;
      if (e >= first && e < last && e >= 0) hist[k][e] = rx;
      if (e == last) begin
        ones = int'(rx);
        for (int i = first; i < last; i++) if (i >= 0 && i < 64) ones += int'(hist[k][i]);
        if (maj) begin
          m_bit[k] = (ones >= h + 1);
          m_noise[k] = (ones != 0) && (ones != n);
        end else begin
          m_bit[k] = (mid == last) ? rx : ((mid >= 0) ? hist[k][mid] : 1'b0);
          m_noise[k] = 1'b0;
        end
        m_val[k] = 1'b1;
      end
    end else begin
      if (p >= 2 && e == mid) begin
        m_bit[k] = rx; m_val[k] = 1'b1; m_noise[k] = 1'b0;
      end else begin
        m_val[k] = 1'b0;
      end
    end
    m_cfg[k] = new_cfg;
  endtask

  task automatic check_all();
    chk("bit3", b3, m_bit[0]);   chk("valid3", v3, m_val[0]);
    chk("noise3", n3, m_noise[0]); chk("cfg3", c3, m_cfg[0]);
    chk("bit5", b5, m_bit[1]);   chk("valid5", v5, m_val[1]);
    chk("noise5", n5, m_noise[1]); chk("cfg5", c5, m_cfg[1]);
  endtask

  task automatic step(input logic r, input logic e_n, input logic mj, input int e, input int p);
    @(negedge clk);
    rx = r; en = e_n; maj = mj; edge_c = 6'(e); presc = 6'(p);
    model_eval(0, 3);
    model_eval(1, 5);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  typedef struct packed {
    logic       rx;
    logic       maj;
    logic [5:0] e;
    logic       xb;
    logic       xv;
    logic       xn;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int strobes, s0, s1, p, prev_p;
    logic base;

    // Table for N=3, Prescale=8 (window 2..4). Fields: rx, maj, edge, then the expected bit, valid and noise.
    tbl[0]  = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 6'd4, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 6'd6, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 6'd2, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 6'd4, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 6'd6, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 6'd4, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst = 1'b0; rx = 1'b0; en = 1'b0; maj = 1'b1; edge_c = 6'd0; presc = 6'd8;
    model_reset();
    #1;
    chk("rst_bit3", b3, 1'b0); chk("rst_valid3", v3, 1'b0);
    chk("rst_noise3", n3, 1'b0); chk("rst_cfg3", c3, 1'b0);
    chk("rst_bit5", b5, 1'b0); chk("rst_cfg5", c5, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven N=3 cases: majority vote, single-sample mode, unanimous zero.
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rx, 1'b1, tbl[i].maj, int'(tbl[i].e), 8);
      chk("tbl_bit", b3, tbl[i].xb);
      chk("tbl_valid", v3, tbl[i].xv);
      chk("tbl_noise", n3, tbl[i].xn);
    end

    // N=5, Prescale=16: a clean zero bit, then 1,1,0,1,1. Strobes must be 16 cycles apart.
    step(1'b0, 1'b0, 1'b1, 0, 16);
    strobes = 0; s0 = -1; s1 = -1;
    for (int c = 0; c < 32; c++) begin
      logic r;
      r = (c >= 21 && c <= 25 && c != 23);
      step(r, 1'b1, 1'b1, c % 16, 16);
      if (v5) begin
        strobes++;
        if (s0 < 0) s0 = c; else s1 = c;
      end
      if (c == 9)  begin chk("n5_b0_bit", b5, 1'b0); chk("n5_b0_noise", n5, 1'b0); end
      if (c == 25) begin chk("n5_b1_bit", b5, 1'b1); chk("n5_b1_noise", n5, 1'b1); end
    end
    chk_int("n5_strobes", strobes, 2);
    chk_int("n5_spacing", s1 - s0, 16);

    // Drop enable mid-window after a 1 decision, then re-enable with 1,1,1.
    step(1'b0, 1'b0, 1'b1, 0, 8);
    for (int e = 0; e < 8; e++) step(1'b1, 1'b1, 1'b1, e, 8);
    chk("pre_drop_bit", b3, 1'b1);
    strobes = 0;
    for (int e = 0; e < 8; e++) begin
      step(1'b1, (e < 3), 1'b1, e, 8);
      if (v3) strobes++;
      if (e == 3) begin
        chk("drop_bit", b3, 1'b0); chk("drop_valid", v3, 1'b0); chk("drop_noise", n3, 1'b0);
      end
    end
    chk_int("drop_strobes", strobes, 0);
    for (int e = 0; e < 8; e++) begin
      step(1'b1, 1'b1, 1'b1, e, 8);
      if (e == 4) begin
        chk("reen_bit", b3, 1'b1); chk("reen_valid", v3, 1'b1); chk("reen_noise", n3, 1'b0);
      end
    end

    // Assert reset mid-window. Outputs must clear at once, and the window after release starts clean.
    for (int e = 0; e < 3; e++) step(1'b1, 1'b1, 1'b1, e, 8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_bit3", b3, 1'b0); chk("arst_valid3", v3, 1'b0); chk("arst_noise3", n3, 1'b0);
    chk("arst_bit5", b5, 1'b0); chk("arst_valid5", v5, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step((e == 3 || e == 4), 1'b1, 1'b1, e, 8);
      if (e == 4) begin
        chk("post_rst_bit", b3, 1'b1); chk("post_rst_noise", n3, 1'b1); chk("post_rst_valid", v3, 1'b1);
      end
    end

    // Fallback: Prescale=4 is too small for N=5, so only the centre sample at edge 1 is used.
    step(1'b0, 1'b0, 1'b1, 0, 4);
    chk("cfg5_set", c5, 1'b1);
    chk("cfg3_clear", c3, 1'b0);
    for (int e = 0; e < 4; e++) begin
      step((e == 1), 1'b1, 1'b1, e, 4);
      if (e == 1) begin chk("fb_valid", v5, 1'b1); chk("fb_bit", b5, 1'b1); chk("fb_noise", n5, 1'b0); end
      else chk("fb_nostrobe", v5, 1'b0);
    end
    // Prescale=1: no strobes at all, and the last decision is held.
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, (i + 2) % 4, 1);
      if (v3 || v5) strobes++;
      chk("p1_hold5", b5, 1'b1);
    end
    chk_int("p1_strobes", strobes, 0);
    chk("p1_cfg3", c3, 1'b1);

    // Random bits checked against the model.
    prev_p = 1;
    for (int b = 0; b < 40; b++) begin
      case ($urandom_range(0, 2))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      if (p != prev_p) step(1'b0, 1'b0, 1'b1, 0, p);
      prev_p = p;
      base = 1'($urandom_range(0, 1));
      for (int e = 0; e < p; e++) begin
        step(base ^ ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) != 0),
             1'($urandom_range(0, 1)), e, p);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
